// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared operation codes, result classes, constants and accumulate FSM encoding
package ex_stage_pkg;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
    localparam logic        RST_ENABLE = 1'b1;
    localparam logic        STOP       = 1'b1;
    localparam logic        NO_STOP    = 1'b0;
    localparam logic [2:0] RES_NOP   = 3'b000;
    localparam logic [2:0] RES_LOGIC = 3'b001;
    localparam logic [2:0] RES_SHIFT = 3'b010;
    localparam logic [2:0] RES_MOVE  = 3'b011;
    localparam logic [2:0] RES_ARITH = 3'b100;
    localparam logic [2:0] RES_MUL   = 3'b101;
    localparam logic [7:0] OP_NOP   = 8'b0000_0000;
    localparam logic [7:0] OP_AND   = 8'b0010_0100;
    localparam logic [7:0] OP_OR    = 8'b0010_0101;
    localparam logic [7:0] OP_XOR   = 8'b0010_0110;
    localparam logic [7:0] OP_NOR   = 8'b0010_0111;
    localparam logic [7:0] OP_SLL   = 8'b0111_1100;
    localparam logic [7:0] OP_SRL   = 8'b0000_0010;
    localparam logic [7:0] OP_SRA   = 8'b0000_0011;
    localparam logic [7:0] OP_MOVZ  = 8'b0000_1010;
    localparam logic [7:0] OP_MOVN  = 8'b0000_1011;
    localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
    localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
    localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
    localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
    localparam logic [7:0] OP_MULT  = 8'b0001_1000;
    localparam logic [7:0] OP_MULTU = 8'b0001_1001;
    localparam logic [7:0] OP_MUL   = 8'b1010_1001;
    localparam logic [7:0] OP_MADD  = 8'b1010_0110;
    localparam logic [7:0] OP_MADDU = 8'b1010_1000;
    localparam logic [7:0] OP_MSUB  = 8'b1010_1010;
    localparam logic [7:0] OP_MSUBU = 8'b1010_1011;
    localparam logic [7:0] OP_CLZ   = 8'b1011_0000;
    localparam logic [7:0] OP_CLO   = 8'b1011_0001;
    typedef enum logic {ST_IDLE = 1'b0, ST_ACC = 1'b1} acc_state_t;
endpackage

// File: rtl/ex_lzc.sv
// ex_lzc: 32-bit leading-zero counter, result 0..32
module ex_lzc (
    input  logic [31:0] x,
    output logic [5:0]  cnt
);
    // highest set bit wins because it is visited last
    always_comb begin
        cnt = 6'd32;
        for (int i = 0; i < 32; i++)
            if (x[i]) cnt = 6'(31 - i);
    end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS32 execute stage (logic/shift/move/multiply, 2-cycle multiply-accumulate); EX_CLZ_EN adds clz/clo
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DW     = 32,
    parameter int HILO_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic [2:0]        alusel_i,
    input  logic [7:0]        aluop_i,
    input  logic [DW-1:0]     reg1_i,
    input  logic [DW-1:0]     reg2_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [DW-1:0]     hi_i,
    input  logic [DW-1:0]     lo_i,
    input  logic              mem_whilo_i,
    input  logic [DW-1:0]     mem_hi_i,
    input  logic [DW-1:0]     mem_lo_i,
    input  logic              wb_whilo_i,
    input  logic [DW-1:0]     wb_hi_i,
    input  logic [DW-1:0]     wb_lo_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [DW-1:0]     wdata_o,
    output logic              whilo_o,
    output logic [DW-1:0]     hi_o,
    output logic [DW-1:0]     lo_o,
    output logic              stallreq
);
    acc_state_t state, state_n;
    logic [HILO_W-1:0] prod_q, product, acc_prod, hilo_sum;
    logic [DW-1:0] hi_fwd, lo_fwd, logic_res, shift_res, move_res, arith_res, mul_res, wdata;
    logic is_acc, is_sub, sgn;
    logic signed [DW:0] opa, opb;
    logic [1:0] prod_unused;
    logic stall_unused;
    assign stall_unused = ^{stall[5:4], stall[2:0]};
    assign hi_fwd = mem_whilo_i ? mem_hi_i : wb_whilo_i ? wb_hi_i : hi_i;
    assign lo_fwd = mem_whilo_i ? mem_lo_i : wb_whilo_i ? wb_lo_i : lo_i;
    assign is_acc = aluop_i inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    assign is_sub = aluop_i inside {OP_MSUB, OP_MSUBU};
    assign sgn    = aluop_i inside {OP_MULT, OP_MUL, OP_MADD, OP_MSUB};
    // one 33x33 signed multiplier serves both signed and unsigned forms
    assign opa = {sgn & reg1_i[DW-1], reg1_i};
    assign opb = {sgn & reg2_i[DW-1], reg2_i};
    assign {prod_unused, product} = opa * opb;
    assign acc_prod = is_sub ? -product : product;
    assign hilo_sum = {hi_fwd, lo_fwd} + prod_q;
`ifdef EX_CLZ_EN
    logic [5:0] clz_cnt, clo_cnt;
    ex_lzc u_clz (.x(reg1_i),  .cnt(clz_cnt));
    ex_lzc u_clo (.x(~reg1_i), .cnt(clo_cnt));
    assign arith_res = aluop_i == OP_CLZ ? DW'(clz_cnt) : aluop_i == OP_CLO ? DW'(clo_cnt) : ZERO_WORD;
`else
    assign arith_res = ZERO_WORD;
`endif
    // per-class results, zero for any code the class does not know
    always_comb begin
        logic_res = aluop_i == OP_AND ? reg1_i & reg2_i :
                    aluop_i == OP_OR  ? reg1_i | reg2_i :
                    aluop_i == OP_XOR ? reg1_i ^ reg2_i :
                    aluop_i == OP_NOR ? ~(reg1_i | reg2_i) : ZERO_WORD;
        shift_res = aluop_i == OP_SLL ? reg2_i << reg1_i[4:0] :
                    aluop_i == OP_SRL ? reg2_i >> reg1_i[4:0] :
                    aluop_i == OP_SRA ? DW'($signed(reg2_i) >>> reg1_i[4:0]) : ZERO_WORD;
        move_res  = aluop_i == OP_MFHI ? hi_fwd :
                    aluop_i == OP_MFLO ? lo_fwd :
                    aluop_i inside {OP_MOVN, OP_MOVZ} ? reg1_i : ZERO_WORD;
        mul_res   = aluop_i == OP_MUL ? product[DW-1:0] : ZERO_WORD;
        wdata     = alusel_i == RES_LOGIC ? logic_res :
                    alusel_i == RES_SHIFT ? shift_res :
                    alusel_i == RES_MOVE  ? move_res :
                    alusel_i == RES_ARITH ? arith_res :
                    alusel_i == RES_MUL   ? mul_res : ZERO_WORD;
    end
    // accumulate state and the product captured on entry to ACC
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state  <= ST_IDLE;
            prod_q <= '0;
        end else begin
            state <= state_n;
            if (state == ST_IDLE && is_acc) prod_q <= acc_prod;
        end
    end
    // next state and stage outputs; reset forces every output to zero
    always_comb begin
        state_n  = state == ST_IDLE ? (is_acc ? ST_ACC : ST_IDLE) : (stall[3] ? ST_ACC : ST_IDLE);
        wd_o     = wd_i;
        wreg_o   = wreg_i;
        wdata_o  = wdata;
        whilo_o  = 1'b0;
        hi_o     = ZERO_WORD;
        lo_o     = ZERO_WORD;
        stallreq = NO_STOP;
        if (aluop_i == OP_MOVN) wreg_o = wreg_i & (reg2_i != ZERO_WORD);
        if (aluop_i == OP_MOVZ) wreg_o = wreg_i & (reg2_i == ZERO_WORD);
        if (aluop_i inside {OP_MULT, OP_MULTU}) begin
            whilo_o       = 1'b1;
            wreg_o        = 1'b0;
            {hi_o, lo_o}  = product;
        end
        if (aluop_i == OP_MTHI) begin
            whilo_o = 1'b1;
            hi_o    = reg1_i;
            lo_o    = lo_fwd;
        end
        if (aluop_i == OP_MTLO) begin
            whilo_o = 1'b1;
            hi_o    = hi_fwd;
            lo_o    = reg1_i;
        end
        if (state == ST_ACC) begin
            whilo_o      = 1'b1;
            wreg_o       = 1'b0;
            {hi_o, lo_o} = hilo_sum;
        end else if (is_acc) begin
            wreg_o   = 1'b0;
            stallreq = STOP;
        end
        if (rst == RST_ENABLE) begin
            wd_o     = '0;
            wreg_o   = 1'b0;
            wdata_o  = ZERO_WORD;
            whilo_o  = 1'b0;
            hi_o     = ZERO_WORD;
            lo_o     = ZERO_WORD;
            stallreq = NO_STOP;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: vector table plus multi-cycle accumulate sequences, scoreboarded against ex_stage
module tb_ex_stage;
    import ex_stage_pkg::*;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst = 1'b1;
    logic [5:0]  stall = '0;
    logic [2:0]  alusel_i = '0;
    logic [7:0]  aluop_i = '0;
    logic [31:0] reg1_i = '0, reg2_i = '0, hi_i = '0, lo_i = '0;
    logic [4:0]  wd_i = '0;
    logic        wreg_i = 1'b0, mem_whilo_i = 1'b0, wb_whilo_i = 1'b0;
    logic [31:0] mem_hi_i = '0, mem_lo_i = '0, wb_hi_i = '0, wb_lo_i = '0;
    logic [4:0]  wd_o;
    logic        wreg_o, whilo_o, stallreq;
    logic [31:0] wdata_o, hi_o, lo_o;
    ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .alusel_i(alusel_i), .aluop_i(aluop_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .hi_i(hi_i), .lo_i(lo_i),
        .mem_whilo_i(mem_whilo_i), .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i),
        .wb_whilo_i(wb_whilo_i), .wb_hi_i(wb_hi_i), .wb_lo_i(wb_lo_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
        .hi_o(hi_o), .lo_o(lo_o), .stallreq(stallreq)
    );
    typedef struct packed {
        logic        rst;
        logic [5:0]  stall;
        logic [2:0]  alusel;
        logic [7:0]  aluop;
        logic [31:0] r1, r2;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] hi, lo;
        logic        mw;
        logic [31:0] mh, ml;
        logic        ww;
        logic [31:0] wh, wl;
    } in_t;
    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi, lo;
        logic        stallreq;
    } out_t;
`ifdef EX_CLZ_EN
    localparam bit CLZ_ON = 1'b1;
`else
    localparam bit CLZ_ON = 1'b0;
`endif
    in_t   tin[$];
    out_t  tout[$];
    string tname[$];
    out_t  exp_q[$];
    string name_q[$];
    int checks = 0;
    int errors = 0;
    function automatic in_t op(logic [2:0] s, logic [7:0] o, logic [31:0] a, logic [31:0] b, logic [4:0] w, logic we);
        in_t v;
        v = '0;
        v.alusel = s;
        v.aluop  = o;
        v.r1     = a;
        v.r2     = b;
        v.wd     = w;
        v.wreg   = we;
        return v;
    endfunction
    function automatic out_t ex(logic [4:0] w, logic we, logic [31:0] d, logic wh, logic [31:0] h, logic [31:0] l, logic st);
        out_t r;
        r.wd = w; r.wreg = we; r.wdata = d; r.whilo = wh; r.hi = h; r.lo = l; r.stallreq = st;
        return r;
    endfunction
    task automatic add(string n, in_t v, out_t e);
        tname.push_back(n);
        tin.push_back(v);
        tout.push_back(e);
    endtask
    task automatic apply(in_t v);
        rst = v.rst; stall = v.stall; alusel_i = v.alusel; aluop_i = v.aluop;
        reg1_i = v.r1; reg2_i = v.r2; wd_i = v.wd; wreg_i = v.wreg; hi_i = v.hi; lo_i = v.lo;
        mem_whilo_i = v.mw; mem_hi_i = v.mh; mem_lo_i = v.ml;
        wb_whilo_i = v.ww; wb_hi_i = v.wh; wb_lo_i = v.wl;
    endtask
    task automatic check();
        out_t g, e;
        string n;
        g = {wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq};
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s: got wd=%0d wreg=%b wdata=%h whilo=%b hi=%h lo=%h stallreq=%b, expected wd=%0d wreg=%b wdata=%h whilo=%b hi=%h lo=%h stallreq=%b",
                     n, g.wd, g.wreg, g.wdata, g.whilo, g.hi, g.lo, g.stallreq,
                     e.wd, e.wreg, e.wdata, e.whilo, e.hi, e.lo, e.stallreq);
        end
    endtask
    task automatic step(string n, in_t v, out_t e);
        @(posedge clk);
        #1;
        apply(v);
        exp_q.push_back(e);
        name_q.push_back(n);
        @(negedge clk);
        check();
    endtask
    out_t zero;
    in_t  v, nop;
    initial begin
        zero = '0;
        nop  = op(RES_NOP, OP_NOP, 0, 0, 0, 0);
        v = op(RES_LOGIC, OP_OR, 32'h0000FF00, 32'h00F0000F, 5, 1); v.rst = 1'b1;
        add("reset_or", v, zero);
        add("reset_hold", v, zero);
        add("or",  op(RES_LOGIC, OP_OR,  32'h0000FF00, 32'h00F0000F, 5, 1), ex(5, 1, 32'h00F0FF0F, 0, 0, 0, 0));
        add("and", op(RES_LOGIC, OP_AND, 32'hFFFF0000, 32'h0F0F0F0F, 1, 1), ex(1, 1, 32'h0F0F0000, 0, 0, 0, 0));
        add("xor", op(RES_LOGIC, OP_XOR, 32'hFF00FF00, 32'h0FF00FF0, 2, 1), ex(2, 1, 32'hF0F0F0F0, 0, 0, 0, 0));
        add("nor", op(RES_LOGIC, OP_NOR, 32'h00000000, 32'hFFFF0000, 3, 1), ex(3, 1, 32'h0000FFFF, 0, 0, 0, 0));
        add("sll", op(RES_SHIFT, OP_SLL, 32'd4,  32'h0000000F, 3, 1), ex(3, 1, 32'h000000F0, 0, 0, 0, 0));
        add("srl", op(RES_SHIFT, OP_SRL, 32'd31, 32'h80000000, 4, 1), ex(4, 1, 32'h00000001, 0, 0, 0, 0));
        add("sra", op(RES_SHIFT, OP_SRA, 32'd4,  32'h80000000, 4, 1), ex(4, 1, 32'hF8000000, 0, 0, 0, 0));
        v = op(RES_MOVE, OP_MFHI, 0, 0, 4, 1); v.hi = 32'h1111; v.mw = 1; v.mh = 32'h12345678; v.ww = 1; v.wh = 32'hDEADBEEF;
        add("mfhi_mem_prio", v, ex(4, 1, 32'h12345678, 0, 0, 0, 0));
        v = op(RES_MOVE, OP_MFLO, 0, 0, 8, 1); v.lo = 32'h1; v.ww = 1; v.wl = 32'hCAFEF00D;
        add("mflo_wb_prio", v, ex(8, 1, 32'hCAFEF00D, 0, 0, 0, 0));
        v = op(RES_MOVE, OP_MFLO, 0, 0, 8, 1); v.lo = 32'h55;
        add("mflo_regfile", v, ex(8, 1, 32'h00000055, 0, 0, 0, 0));
        add("movn_taken", op(RES_MOVE, OP_MOVN, 32'hABCD, 32'd1, 6, 1), ex(6, 1, 32'hABCD, 0, 0, 0, 0));
        add("movn_skip",  op(RES_MOVE, OP_MOVN, 32'hABCD, 32'd0, 6, 1), ex(6, 0, 32'hABCD, 0, 0, 0, 0));
        add("movz_taken", op(RES_MOVE, OP_MOVZ, 32'h1234, 32'd0, 7, 1), ex(7, 1, 32'h1234, 0, 0, 0, 0));
        add("movz_skip",  op(RES_MOVE, OP_MOVZ, 32'h1234, 32'd5, 7, 1), ex(7, 0, 32'h1234, 0, 0, 0, 0));
        v = op(RES_NOP, OP_MTHI, 32'hAAAA, 0, 0, 0); v.hi = 32'h5; v.lo = 32'h77;
        add("mthi", v, ex(0, 0, 0, 1, 32'hAAAA, 32'h77, 0));
        v = op(RES_NOP, OP_MTLO, 32'hBEEF, 0, 0, 0); v.hi = 32'h1; v.mw = 1; v.mh = 32'h99; v.ml = 32'h3;
        add("mtlo_fwd", v, ex(0, 0, 0, 1, 32'h99, 32'hBEEF, 0));
        add("mult",  op(RES_NOP, OP_MULT,  32'h80000000, 32'h2, 0, 0), ex(0, 0, 0, 1, 32'hFFFFFFFF, 32'h0, 0));
        add("multu", op(RES_NOP, OP_MULTU, 32'h80000000, 32'h2, 0, 0), ex(0, 0, 0, 1, 32'h1, 32'h0, 0));
        add("mul",   op(RES_MUL, OP_MUL,   32'hFFFFFFFD, 32'h5, 9, 1), ex(9, 1, 32'hFFFFFFF1, 0, 0, 0, 0));
        add("nop",   op(RES_NOP, OP_NOP,   32'h1234, 32'h5678, 7, 1), ex(7, 1, 0, 0, 0, 0, 0));
        add("unknown_op", op(RES_LOGIC, 8'hEE, 32'hFFFF, 32'hFFFF, 2, 1), ex(2, 1, 0, 0, 0, 0, 0));
        add("clz_15", op(RES_ARITH, OP_CLZ, 32'h00010000, 0, 1, 1), ex(1, 1, CLZ_ON ? 32'd15 : 32'd0, 0, 0, 0, 0));
        add("clz_0",  op(RES_ARITH, OP_CLZ, 32'h00000000, 0, 1, 1), ex(1, 1, CLZ_ON ? 32'd32 : 32'd0, 0, 0, 0, 0));
        add("clo_all", op(RES_ARITH, OP_CLO, 32'hFFFFFFFF, 0, 1, 1), ex(1, 1, CLZ_ON ? 32'd32 : 32'd0, 0, 0, 0, 0));
        add("clo_4",  op(RES_ARITH, OP_CLO, 32'hF0000000, 0, 1, 1), ex(1, 1, CLZ_ON ? 32'd4 : 32'd0, 0, 0, 0, 0));
        for (int i = 0; i < tin.size(); i++) step(tname[i], tin[i], tout[i]);
        v = op(RES_NOP, OP_MADD, 32'hFFFFFFFE, 32'd3, 0, 0); v.lo = 32'h10; v.stall = 6'b001111;
        step("madd_c1", v, ex(0, 0, 0, 0, 0, 0, 1));
        v.stall = '0;
        step("madd_c2", v, ex(0, 0, 0, 1, 32'h0, 32'hA, 0));
        step("madd_idle", nop, zero);
        v = op(RES_NOP, OP_MSUBU, 32'h2, 32'h3, 0, 0);
        step("msubu_c1", v, ex(0, 0, 0, 0, 0, 0, 1));
        v.stall = 6'b001000;
        for (int i = 0; i < 4; i++) step($sformatf("msubu_held_%0d", i), v, ex(0, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFA, 0));
        v.stall = '0;
        step("msubu_release", v, ex(0, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFA, 0));
        step("msubu_idle", nop, zero);
        v = op(RES_NOP, OP_MADD, 32'hFFFFFFFE, 32'd3, 9, 0); v.lo = 32'h10;
        step("rst_madd_c1", v, ex(9, 0, 0, 0, 0, 0, 1));
        v.rst = 1'b1;
        step("rst_in_acc", v, zero);
        step("rst_aborted", nop, zero);
        v.rst = 1'b0;
        step("madd_restart_c1", v, ex(9, 0, 0, 0, 0, 0, 1));
        step("madd_restart_c2", v, ex(9, 0, 0, 1, 32'h0, 32'hA, 0));
        step("final_idle", nop, zero);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
